// File: rtl/branch_resolution_unit_pkg.sv
// rtl/branch_resolution_unit_pkg.sv - shared types and helpers for the branch resolution unit
// Purpose: widths, lane/update/payload structs, FSM state enum and the 2-bit
// saturating PHT counter update used by the resolution unit and its FIFO.
package branch_resolution_unit_pkg;

    localparam int ISSUE_WIDTH   = 2;
    localparam int ADDR_WIDTH    = 32;
    localparam int AL_PTR_WIDTH  = 6;
    localparam int PHT_IDX_WIDTH = 10;
    localparam int GHR_WIDTH     = 10;
    localparam int UPD_DEPTH     = 8;
    localparam int UPD_WIDTH     = PHT_IDX_WIDTH + 2;
    localparam int LANE_CNT_W    = $clog2(ISSUE_WIDTH + 1);

    typedef struct packed {
        logic                     valid;
        logic                     mispred;
        logic                     isCond;
        logic                     execTaken;
        logic [ADDR_WIDTH-1:0]    nextAddr;
        logic [AL_PTR_WIDTH-1:0]  alPtr;
        logic [PHT_IDX_WIDTH-1:0] phtIdx;
        logic [1:0]               phtPrev;
        logic [GHR_WIDTH-1:0]     ghist;
    } laneResult_t;

    typedef struct packed {
        logic [PHT_IDX_WIDTH-1:0] idx;
        logic [1:0]               value;
    } phtUpdate_t;

    // Recovery payload: what is held in REQ and what waits in the deferred slot.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   target;
        logic [AL_PTR_WIDTH-1:0] alPtr;
        logic [GHR_WIDTH-1:0]    ghist;
    } recPayload_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } bruState_t;

    function automatic logic [1:0] satUpdate(input logic [1:0] prev, input logic taken);
        if (taken) begin
            return (prev == 2'd3) ? 2'd3 : prev + 2'd1;
        end
        return (prev == 2'd0) ? 2'd0 : prev - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// rtl/branch_resolution_unit_if.sv - branch result, recovery and PHT update bus
// Purpose: bundles the execution-stage branch results, the recovery manager
// handshake, the PHT update handshake and the drop counter.
// master: the resolution unit (consumes br_*, drives rec_*/upd_*/drop_count).
// slave : the surrounding pipeline / recovery manager / predictor.
interface branch_resolution_unit_if;
    import branch_resolution_unit_pkg::*;

    logic [AL_PTR_WIDTH-1:0]               al_head_ptr;
    logic [ISSUE_WIDTH-1:0]                br_valid;
    logic [ISSUE_WIDTH-1:0]                br_mispred;
    logic [ISSUE_WIDTH-1:0]                br_is_cond;
    logic [ISSUE_WIDTH-1:0]                br_exec_taken;
    logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]     br_next_addr;
    logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0]   br_al_ptr;
    logic [ISSUE_WIDTH*PHT_IDX_WIDTH-1:0]  br_pht_idx;
    logic [ISSUE_WIDTH*2-1:0]              br_pht_prev;
    logic [ISSUE_WIDTH*GHR_WIDTH-1:0]      br_ghist;

    logic                                  rec_req;
    logic [ADDR_WIDTH-1:0]                 rec_target;
    logic [AL_PTR_WIDTH-1:0]               rec_al_ptr;
    logic [GHR_WIDTH-1:0]                  rec_ghist;
    logic                                  rec_ack;
    logic                                  rec_done;

    logic                                  upd_valid;
    logic [PHT_IDX_WIDTH-1:0]              upd_idx;
    logic [1:0]                            upd_value;
    logic                                  upd_ready;
    logic [15:0]                           drop_count;

    modport master (
        input  al_head_ptr, br_valid, br_mispred, br_is_cond, br_exec_taken,
               br_next_addr, br_al_ptr, br_pht_idx, br_pht_prev, br_ghist,
               rec_ack, rec_done, upd_ready,
        output rec_req, rec_target, rec_al_ptr, rec_ghist,
               upd_valid, upd_idx, upd_value, drop_count
    );

    modport slave (
        output al_head_ptr, br_valid, br_mispred, br_is_cond, br_exec_taken,
               br_next_addr, br_al_ptr, br_pht_idx, br_pht_prev, br_ghist,
               rec_ack, rec_done, upd_ready,
        input  rec_req, rec_target, rec_al_ptr, rec_ghist,
               upd_valid, upd_idx, upd_value, drop_count
    );

endinterface

// File: rtl/branch_update_fifo.sv
// rtl/branch_update_fifo.sv - multi-push, single-pop FIFO for PHT updates
// Purpose: accepts up to LANES pushes per cycle in lane order, pops one entry.
// Ports: clk, rst (sync active-high), pushValid/pushData (per lane),
// pushAccepted (number of lanes written), popValid/popData/popReady (head).
module branch_update_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            pushValid,
    input  logic [LANES-1:0][WIDTH-1:0] pushData,
    output logic [AW-1:0]               pushAccepted,
    output logic                        popValid,
    output logic [WIDTH-1:0]            popData,
    input  logic                        popReady
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             popFire;
    logic [AW-1:0]    nAcc;
    logic [LANES-1:0] wrEn;
    logic [PW-1:0]    wrAddr [LANES];

    assign popValid = (count != '0);
    assign popFire  = popValid && popReady;
    // Storage is not reset, so the head is masked while empty.
    assign popData  = popValid ? mem[rdPtr] : '0;

    // A same-cycle pop frees a slot; lanes are packed densely, lowest first.
    always_comb begin
        free = CW'(DEPTH) - count + CW'(popFire);
        nAcc = '0;
        for (int l = 0; l < LANES; l++) begin
            wrEn[l]   = 1'b0;
            wrAddr[l] = wrPtr + PW'(nAcc);
            if (pushValid[l] && (CW'(nAcc) < free)) begin
                wrEn[l] = 1'b1;
                nAcc    = nAcc + AW'(1);
            end
        end
    end

    assign pushAccepted = nAcc;

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wrEn[l]) begin
                mem[wrAddr[l]] <= pushData[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(nAcc);
            rdPtr <= rdPtr + PW'(popFire);
            count <= count + CW'(nAcc) - CW'(popFire);
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - oldest-mispredict recovery and PHT update drain
// Purpose: picks the oldest mispredicted branch each cycle, holds a recovery
// request until acked, defers older mispredicts seen during a flush, and
// queues conditional-branch PHT updates for the predictor.
// Ports: clk, rst (sync active-high), bus (branch_resolution_unit_if.master).
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    branch_resolution_unit_if.master        bus
);
    laneResult_t             lanes [ISSUE_WIDTH];
    logic                    candValid;
    recPayload_t             cand;
    logic [AL_PTR_WIDTH-1:0] candAge;
    logic [AL_PTR_WIDTH-1:0] laneAge;
    logic [AL_PTR_WIDTH-1:0] heldAge;
    logic [AL_PTR_WIDTH-1:0] deferredAge;
    logic                    candOlderHeld;
    logic                    newDeferredValid;
    recPayload_t             newDeferred;

    bruState_t               state;
    logic                    recReq;
    recPayload_t             held;
    logic                    deferredValid;
    recPayload_t             deferred;

    always_comb begin
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            lanes[l].valid     = bus.br_valid[l];
            lanes[l].mispred   = bus.br_mispred[l];
            lanes[l].isCond    = bus.br_is_cond[l];
            lanes[l].execTaken = bus.br_exec_taken[l];
            lanes[l].nextAddr  = bus.br_next_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
            lanes[l].alPtr     = bus.br_al_ptr[l*AL_PTR_WIDTH +: AL_PTR_WIDTH];
            lanes[l].phtIdx    = bus.br_pht_idx[l*PHT_IDX_WIDTH +: PHT_IDX_WIDTH];
            lanes[l].phtPrev   = bus.br_pht_prev[l*2 +: 2];
            lanes[l].ghist     = bus.br_ghist[l*GHR_WIDTH +: GHR_WIDTH];
        end
    end

    // Ages are distances from the active-list head, so wrap-around is handled
    // by the modular subtraction. Strict '<' lets the lower lane win ties.
    always_comb begin
        candValid = 1'b0;
        cand      = '0;
        candAge   = '0;
        laneAge   = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            laneAge = lanes[l].alPtr - bus.al_head_ptr;
            if (lanes[l].valid && lanes[l].mispred && (!candValid || laneAge < candAge)) begin
                candValid    = 1'b1;
                candAge      = laneAge;
                cand.target  = lanes[l].nextAddr;
                cand.alPtr   = lanes[l].alPtr;
                cand.ghist   = lanes[l].ghist;
            end
        end
    end

    assign heldAge       = held.alPtr - bus.al_head_ptr;
    assign deferredAge   = deferred.alPtr - bus.al_head_ptr;
    assign candOlderHeld = candValid && (candAge < heldAge);

    // Deferred slot after this cycle's candidate: keeps the oldest mispredict
    // that is older than the payload already handed to the recovery manager.
    always_comb begin
        newDeferredValid = deferredValid;
        newDeferred      = deferred;
        if (candOlderHeld && (!deferredValid || candAge < deferredAge)) begin
            newDeferredValid = 1'b1;
            newDeferred      = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            recReq        <= 1'b0;
            held          <= '0;
            deferredValid <= 1'b0;
            deferred      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (candValid) begin
                        held   <= cand;
                        recReq <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.rec_ack) begin
                        // The held payload is what got accepted; an older
                        // candidate in the ack cycle waits for the flush.
                        deferredValid <= newDeferredValid;
                        deferred      <= newDeferred;
                        recReq        <= 1'b0;
                        state         <= WAIT;
                    end else if (candOlderHeld) begin
                        held <= cand;
                    end
                end
                WAIT: begin
                    if (bus.rec_done) begin
                        if (newDeferredValid) begin
                            held   <= newDeferred;
                            recReq <= 1'b1;
                            state  <= REQ;
                        end else begin
                            state  <= IDLE;
                        end
                        deferredValid <= 1'b0;
                    end else begin
                        deferredValid <= newDeferredValid;
                        deferred      <= newDeferred;
                    end
                end
                default: begin
                    state  <= IDLE;
                    recReq <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rec_req    = recReq;
    assign bus.rec_target = held.target;
    assign bus.rec_al_ptr = held.alPtr;
    assign bus.rec_ghist  = held.ghist;

    logic [ISSUE_WIDTH-1:0]                pushValid;
    logic [ISSUE_WIDTH-1:0][UPD_WIDTH-1:0] pushData;
    logic [LANE_CNT_W-1:0]                 numPush;
    logic [LANE_CNT_W-1:0]                 accepted;
    logic [LANE_CNT_W-1:0]                 dropped;
    logic [UPD_WIDTH-1:0]                  headData;
    phtUpdate_t                            headEntry;
    logic [15:0]                           dropCount;
    logic [16:0]                           dropSum;

    always_comb begin
        numPush = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            pushValid[l] = lanes[l].valid && lanes[l].isCond;
            pushData[l]  = phtUpdate_t'{idx:   lanes[l].phtIdx,
                                        value: satUpdate(lanes[l].phtPrev, lanes[l].execTaken)};
            numPush      = numPush + LANE_CNT_W'(pushValid[l]);
        end
    end

    branch_update_fifo #(
        .LANES (ISSUE_WIDTH),
        .DEPTH (UPD_DEPTH),
        .WIDTH (UPD_WIDTH),
        .AW    (LANE_CNT_W)
    ) updateFifo (
        .clk          (clk),
        .rst          (rst),
        .pushValid    (pushValid),
        .pushData     (pushData),
        .pushAccepted (accepted),
        .popValid     (bus.upd_valid),
        .popData      (headData),
        .popReady     (bus.upd_ready)
    );

    assign headEntry     = phtUpdate_t'(headData);
    assign bus.upd_idx   = headEntry.idx;
    assign bus.upd_value = headEntry.value;

    assign dropped = numPush - accepted;
    assign dropSum = {1'b0, dropCount} + 17'(dropped);

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCount <= '0;
        end else begin
            dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

    assign bus.drop_count = dropCount;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - directed self-checking bench for branch_resolution_unit
module tb_branch_resolution_unit;
    import branch_resolution_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_resolution_unit_if bruIf();

    branch_resolution_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bruIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLanes();
        bruIf.br_valid      = '0;
        bruIf.br_mispred    = '0;
        bruIf.br_is_cond    = '0;
        bruIf.br_exec_taken = '0;
        bruIf.br_next_addr  = '0;
        bruIf.br_al_ptr     = '0;
        bruIf.br_pht_idx    = '0;
        bruIf.br_pht_prev   = '0;
        bruIf.br_ghist      = '0;
    endtask

    task automatic setLane(input int l, input logic mis, input logic cond, input logic taken,
                           input logic [31:0] addr, input logic [5:0] ptr,
                           input logic [9:0] idx, input logic [1:0] prev, input logic [9:0] gh);
        bruIf.br_valid[l]             = 1'b1;
        bruIf.br_mispred[l]           = mis;
        bruIf.br_is_cond[l]           = cond;
        bruIf.br_exec_taken[l]        = taken;
        bruIf.br_next_addr[l*32 +: 32] = addr;
        bruIf.br_al_ptr[l*6 +: 6]     = ptr;
        bruIf.br_pht_idx[l*10 +: 10]  = idx;
        bruIf.br_pht_prev[l*2 +: 2]   = prev;
        bruIf.br_ghist[l*10 +: 10]    = gh;
    endtask

    task automatic ackAndDone();
        bruIf.rec_ack = 1'b1;
        tick();
        bruIf.rec_ack  = 1'b0;
        bruIf.rec_done = 1'b1;
        tick();
        bruIf.rec_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clearLanes();
        bruIf.al_head_ptr = '0;
        bruIf.rec_ack     = 1'b0;
        bruIf.rec_done    = 1'b0;
        bruIf.upd_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkVal("rst_rec_req",    bruIf.rec_req,    0);
        checkVal("rst_rec_target", bruIf.rec_target, 0);
        checkVal("rst_rec_al_ptr", bruIf.rec_al_ptr, 0);
        checkVal("rst_rec_ghist",  bruIf.rec_ghist,  0);
        checkVal("rst_upd_valid",  bruIf.upd_valid,  0);
        checkVal("rst_upd_idx",    bruIf.upd_idx,    0);
        checkVal("rst_upd_value",  bruIf.upd_value,  0);
        checkVal("rst_drop_count", bruIf.drop_count, 0);

        // Two mispredicts in one cycle: ptr 3 (lane1) is older than ptr 5.
        setLane(0, 1, 0, 0, 32'h1000, 6'd5, 10'h0, 2'd0, 10'h011);
        setLane(1, 1, 0, 0, 32'h2000, 6'd3, 10'h0, 2'd0, 10'h022);
        checkVal("a_req_before", bruIf.rec_req, 0);
        tick();
        clearLanes();
        checkVal("a_req",    bruIf.rec_req,    1);
        checkVal("a_target", bruIf.rec_target, 32'h2000);
        checkVal("a_ptr",    bruIf.rec_al_ptr, 3);
        checkVal("a_ghist",  bruIf.rec_ghist,  10'h022);
        checkVal("a_no_upd", bruIf.upd_valid,  0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("a_hold_req",    bruIf.rec_req,    1);
            checkVal("a_hold_target", bruIf.rec_target, 32'h2000);
            checkVal("a_hold_ptr",    bruIf.rec_al_ptr, 3);
        end
        bruIf.rec_ack = 1'b1;
        tick();
        bruIf.rec_ack = 1'b0;
        checkVal("a_wait_req", bruIf.rec_req, 0);
        bruIf.rec_done = 1'b1;
        tick();
        bruIf.rec_done = 1'b0;
        checkVal("a_idle_req", bruIf.rec_req, 0);

        // Older candidate replaces the held payload when not acked.
        setLane(0, 1, 0, 0, 32'hA0, 6'd10, 10'h0, 2'd0, 10'h00A);
        tick();
        checkVal("b_ptr10", bruIf.rec_al_ptr, 10);
        setLane(0, 1, 0, 0, 32'h70, 6'd7, 10'h0, 2'd0, 10'h007);
        tick();
        clearLanes();
        checkVal("b_repl_ptr",    bruIf.rec_al_ptr, 7);
        checkVal("b_repl_target", bruIf.rec_target, 32'h70);
        checkVal("b_repl_req",    bruIf.rec_req,    1);
        ackAndDone();
        checkVal("b_idle_req", bruIf.rec_req, 0);

        // Older candidate in the ack cycle is deferred; younger one in WAIT dropped.
        setLane(0, 1, 0, 0, 32'hA0, 6'd10, 10'h0, 2'd0, 10'h00A);
        tick();
        checkVal("b2_ptr10", bruIf.rec_al_ptr, 10);
        setLane(0, 1, 0, 0, 32'h70, 6'd7, 10'h0, 2'd0, 10'h007);
        bruIf.rec_ack = 1'b1;
        tick();
        clearLanes();
        bruIf.rec_ack = 1'b0;
        checkVal("b2_wait_req", bruIf.rec_req,    0);
        checkVal("b2_accepted", bruIf.rec_al_ptr, 10);
        setLane(0, 1, 0, 0, 32'h200, 6'd20, 10'h0, 2'd0, 10'h014);
        tick();
        clearLanes();
        bruIf.rec_done = 1'b1;
        tick();
        bruIf.rec_done = 1'b0;
        checkVal("b2_def_req",    bruIf.rec_req,    1);
        checkVal("b2_def_ptr",    bruIf.rec_al_ptr, 7);
        checkVal("b2_def_target", bruIf.rec_target, 32'h70);
        ackAndDone();
        checkVal("b2_idle_req", bruIf.rec_req, 0);

        // Wrap: head 60, ptr 62 (age 2) beats ptr 1 (age 5).
        bruIf.al_head_ptr = 6'd60;
        setLane(0, 1, 0, 0, 32'h100, 6'd1,  10'h0, 2'd0, 10'h001);
        setLane(1, 1, 0, 0, 32'h620, 6'd62, 10'h0, 2'd0, 10'h03E);
        tick();
        clearLanes();
        checkVal("c_ptr",    bruIf.rec_al_ptr, 62);
        checkVal("c_target", bruIf.rec_target, 32'h620);
        ackAndDone();
        bruIf.al_head_ptr = '0;

        // Counter update values and unconditional lanes.
        bruIf.upd_ready = 1'b0;
        setLane(0, 0, 1, 1, 32'h0, 6'd0, 10'h011, 2'd3, 10'h0);
        setLane(1, 0, 1, 0, 32'h0, 6'd0, 10'h022, 2'd0, 10'h0);
        tick();
        clearLanes();
        checkVal("d_valid1", bruIf.upd_valid, 1);
        checkVal("d_idx1",   bruIf.upd_idx,   10'h011);
        checkVal("d_val1",   bruIf.upd_value, 3);
        bruIf.upd_ready = 1'b1;
        tick();
        checkVal("d_idx2", bruIf.upd_idx,   10'h022);
        checkVal("d_val2", bruIf.upd_value, 0);
        setLane(0, 0, 1, 1, 32'h0, 6'd0, 10'h033, 2'd1, 10'h0);
        setLane(1, 0, 0, 0, 32'h40, 6'd9, 10'h044, 2'd1, 10'h0);
        tick();
        clearLanes();
        checkVal("d_valid3", bruIf.upd_valid, 1);
        checkVal("d_idx3",   bruIf.upd_idx,   10'h033);
        checkVal("d_val3",   bruIf.upd_value, 2);
        tick();
        checkVal("d_jump_nopush", bruIf.upd_valid, 0);
        bruIf.upd_ready = 1'b0;

        // Fill: 4 cycles of two pushes fill 8 entries; the 5th drops both.
        for (int c = 0; c < 5; c++) begin
            setLane(0, 0, 1, 1, 32'h0, 6'd0, 10'(10'h100 + 2*c),     2'd1, 10'h0);
            setLane(1, 0, 1, 0, 32'h0, 6'd0, 10'(10'h100 + 2*c + 1), 2'd2, 10'h0);
            tick();
            if (c == 3) checkVal("e_drop_before_full", bruIf.drop_count, 0);
        end
        clearLanes();
        checkVal("e_drop_count", bruIf.drop_count, 2);
        bruIf.upd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkVal("e_pop_valid", bruIf.upd_valid, 1);
            checkVal("e_pop_idx",   bruIf.upd_idx,   10'h100 + k);
            checkVal("e_pop_value", bruIf.upd_value, (k % 2 == 0) ? 2 : 1);
            tick();
        end
        checkVal("e_empty", bruIf.upd_valid, 0);
        bruIf.upd_ready = 1'b0;

        // Reset in WAIT with a deferred entry and a non-empty FIFO.
        setLane(0, 1, 0, 0, 32'hA0, 6'd10, 10'h0, 2'd0, 10'h00A);
        tick();
        setLane(0, 1, 0, 0, 32'h70, 6'd7, 10'h0, 2'd0, 10'h007);
        setLane(1, 0, 1, 1, 32'h0, 6'd0, 10'h055, 2'd1, 10'h0);
        bruIf.rec_ack = 1'b1;
        tick();
        clearLanes();
        bruIf.rec_ack = 1'b0;
        checkVal("f_pre_upd", bruIf.upd_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("f_rec_req",    bruIf.rec_req,    0);
        checkVal("f_rec_ptr",    bruIf.rec_al_ptr, 0);
        checkVal("f_upd_valid",  bruIf.upd_valid,  0);
        checkVal("f_drop_count", bruIf.drop_count, 0);
        bruIf.rec_done = 1'b1;
        tick();
        bruIf.rec_done = 1'b0;
        checkVal("f_no_deferred", bruIf.rec_req, 0);
        tick();
        checkVal("f_still_idle", bruIf.rec_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Consumes per-lane branch results from the integer execution stage (the receiving end of its branch-result output).
- Selects the oldest mispredicted branch in the window and drives a held recovery request to the recovery manager.
- Buffers conditional-branch outcomes in a FIFO and drains them, one per cycle, to the branch predictor's PHT update port.

Parameters:
- ISSUE_WIDTH, 2, number of integer lanes delivering branch results per cycle
- ADDR_WIDTH, 32, PC width
- AL_PTR_WIDTH, 6, active-list pointer width; age is computed mod 2^AL_PTR_WIDTH
- PHT_IDX_WIDTH, 10, PHT index width
- GHR_WIDTH, 10, global history width
- UPD_DEPTH, 8, update FIFO entries; must be a power of two and at least ISSUE_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- al_head_ptr  in  AL_PTR_WIDTH  active-list head pointer, used as the age reference
- br_valid  in  ISSUE_WIDTH  lane carries a resolved branch
- br_mispred  in  ISSUE_WIDTH  lane was mispredicted
- br_is_cond  in  ISSUE_WIDTH  lane is a conditional branch
- br_exec_taken  in  ISSUE_WIDTH  resolved direction
- br_next_addr  in  ISSUE_WIDTH*ADDR_WIDTH  correct next PC
- br_al_ptr  in  ISSUE_WIDTH*AL_PTR_WIDTH  active-list pointer of the branch
- br_pht_idx  in  ISSUE_WIDTH*PHT_IDX_WIDTH  PHT index used at prediction
- br_pht_prev  in  ISSUE_WIDTH*2  PHT counter value at prediction
- br_ghist  in  ISSUE_WIDTH*GHR_WIDTH  global history at prediction
- rec_req  out  1  recovery request valid
- rec_target  out  ADDR_WIDTH  refetch PC
- rec_al_ptr  out  AL_PTR_WIDTH  pointer of the mispredicted branch
- rec_ghist  out  GHR_WIDTH  history to restore
- rec_ack  in  1  recovery manager accepted the request
- rec_done  in  1  flush complete (single-cycle pulse)
- upd_valid  out  1  PHT update available
- upd_idx  out  PHT_IDX_WIDTH  PHT index to write
- upd_value  out  2  new counter value
- upd_ready  in  1  predictor accepts the update
- drop_count  out  16  saturating count of updates dropped because the FIFO was full

Behaviour:
- Reset values: rec_req=0, rec_target=0, rec_al_ptr=0, rec_ghist=0, upd_valid=0, upd_idx=0, upd_value=0, drop_count=0. FSM enters IDLE, FIFO is emptied, deferred register is invalid.
- Age: age(p) = (p - al_head_ptr) mod 2^AL_PTR_WIDTH. Smaller age is older. On equal age the lower lane wins.
- Candidate per cycle: the oldest lane with br_valid & br_mispred.
- FSM IDLE: if a candidate exists, latch target, pointer and ghist, then go to REQ. rec_req rises the next cycle (one-cycle latency).
- FSM REQ:
  - rec_req=1 and its payload is held stable until rec_ack.
  - A candidate older than the held one, arriving before or in the ack cycle, replaces the payload. The replacement takes effect in the same cycle only if ack=0.
  - If ack=1, the held payload is the one accepted, and the older candidate is written to the deferred register instead.
  - On rec_ack, go to WAIT.
- FSM WAIT:
  - rec_req=0.
  - A candidate older than the accepted pointer is written to the deferred register, keeping the oldest. Younger candidates are dropped.
  - On rec_done: if deferred is valid, load it and go to REQ; otherwise go to IDLE.
  - A candidate arriving in the rec_done cycle itself is treated as in WAIT.
- Update FIFO push: each lane with br_valid & br_is_cond pushes {idx, value}, in lane order. Non-conditional branches are never pushed.
  - value = taken ? min(prev+1, 3) : max(prev-1, 0).
- Push/pop ordering: a pop (upd_valid & upd_ready) in the same cycle frees a slot that pushes may use.
- FIFO full: lanes that do not fit are dropped, lowest lanes kept. drop_count increases by the number dropped, saturating at 0xFFFF.
- upd_valid = FIFO not empty. Head entry is shown combinationally from storage, so a push into an empty FIFO appears the next cycle.
- Pointers wrap mod UPD_DEPTH. A count of log2(UPD_DEPTH)+1 bits separates full from empty.
- Recovery does not flush the FIFO; wrong-path updates are acceptable training noise.
- Reset asserted mid-operation abandons any pending request and any deferred entry, with no ack required.

Decomposition:
- Shared package (branch-resolution types): lane struct {valid, mispred, isCond, execTaken, nextAddr, alPtr, phtIdx, phtPrev, ghist}, PHT update struct, FSM state enum {IDLE, REQ, WAIT}, and the 2-bit saturating-update function.
- Sub-module: branch_update_fifo, a multi-push (ISSUE_WIDTH), single-pop FIFO that returns an accepted-push count.
- Age compare and oldest-select stay inline.

Test Plan:
- Head=0; lane0 mispred ptr=5, target=0x1000, in the same cycle as lane1 mispred ptr=3, target=0x2000 -> next cycle rec_req=1, rec_target=0x2000, rec_al_ptr=3; held unchanged through 4 stall cycles until rec_ack.
- In REQ with held ptr=10, mispred ptr=7 arrives with ack=0 -> payload becomes ptr=7. Repeat with ack=1 -> ptr=10 accepted, ptr=7 deferred; after rec_done, REQ with ptr=7.
- Wrap: head=60, ptrs 62 and 1 mispredict together -> ptr=62 chosen.
- Both lanes conditional every cycle, upd_ready=0, UPD_DEPTH=8 -> full after 4 cycles; the 5th cycle gives drop_count=2. Then upd_ready=1 -> 8 entries pop in push order.
- prev=3 taken -> value 3; prev=0 not-taken -> value 0; prev=1 taken -> value 2; unconditional jump lanes -> no push.
- Reset asserted in WAIT with deferred valid -> next cycle IDLE, rec_req=0, FIFO empty, drop_count=0.
